// File: rtl/alu_result_collector_if.sv
// Handshake bundle between the alu32 result producer, the result collector
// and the downstream consumer. The master side is the producer/consumer pair
// (or a bench). The slave side is the collector.
interface alu_result_collector_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_s;
    logic             in_cout;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_op;
    logic [WIDTH-1:0] out_s;
    logic             out_cout;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] count;
    logic             drop_sticky;

    modport master (
        output in_valid, in_op, in_s, in_cout, out_ready,
        input  in_ready, out_valid, out_op, out_s, out_cout, out_zero, out_neg,
               count, drop_sticky
    );

    modport slave (
        input  in_valid, in_op, in_s, in_cout, out_ready,
        output in_ready, out_valid, out_op, out_s, out_cout, out_zero, out_neg,
               count, drop_sticky
    );
endinterface

// File: rtl/alu_result_collector.sv
// Receive end of the alu32 result path: a show-ahead FIFO of
// {op, cout, result} entries with valid/ready on both sides.
// Optional feature macro: ALU_FLAGS_EN stores zero/negative flags per entry
// and presents them on out_zero/out_neg. Without it, both flags read 0.
module alu_result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic                   clk,
    input logic                   reset,
    alu_result_collector_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef ALU_FLAGS_EN
    localparam int ENT_W = WIDTH + 6;
`else
    localparam int ENT_W = WIDTH + 4;
`endif

    // Entry layout: [WIDTH-1:0] result, [WIDTH] carry, [WIDTH+3:WIDTH+1] op,
    // and with flags enabled [WIDTH+4] zero, [WIDTH+5] negative.
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] wdata;
    logic [ENT_W-1:0] head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;
    logic             full, empty, push, pop;

    // Next-state for pointers, occupancy and the drop flag. Full refuses a
    // push even when the head pops in the same cycle.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        push     = bus.in_valid & ~full;
        pop      = bus.out_ready & ~empty;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        drop_d = drop_q | (bus.in_valid & full);
    end

    // Control state, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Pack the incoming result; flags are derived here so the head path is
    // a plain read.
    always_comb begin
        wdata = '0;
        wdata[WIDTH-1:0]       = bus.in_s;
        wdata[WIDTH]           = bus.in_cout;
        wdata[WIDTH+3:WIDTH+1] = bus.in_op;
`ifdef ALU_FLAGS_EN
        wdata[WIDTH+4] = ~|bus.in_s;
        wdata[WIDTH+5] = bus.in_s[WIDTH-1];
`endif
    end

    // Storage array; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Show-ahead head presentation, masked to 0 while empty.
    always_comb begin
        head          = mem_q[rd_ptr_q];
        bus.in_ready  = ~full;
        bus.out_valid = ~empty;
        bus.out_op    = '0;
        bus.out_s     = '0;
        bus.out_cout  = 1'b0;
        bus.out_zero  = 1'b0;
        bus.out_neg   = 1'b0;
        if (!empty) begin
            bus.out_op   = head[WIDTH+3:WIDTH+1];
            bus.out_s    = head[WIDTH-1:0];
            bus.out_cout = head[WIDTH];
`ifdef ALU_FLAGS_EN
            bus.out_zero = head[WIDTH+4];
            bus.out_neg  = head[WIDTH+5];
`endif
        end
        bus.count       = count_q;
        bus.drop_sticky = drop_q;
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: reset, single push, fill/overflow
// and drain, steady streaming across pointer wrap, empty pop, and mid-run reset.
module tb_alu_result_collector;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
`ifdef ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_result_collector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] s,
                         input logic c, input logic rdy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_s      = s;
        bus.in_cout   = c;
        bus.out_ready = rdy;
    endtask

    task automatic check_head(input string tag, input logic [2:0] op, input logic [31:0] s,
                              input logic c, input logic z, input logic n);
        check({tag, ".valid"}, bus.out_valid, 1'b1);
        check({tag, ".op"}, bus.out_op, op);
        check({tag, ".s"}, bus.out_s, s);
        check({tag, ".cout"}, bus.out_cout, c);
        check({tag, ".zero"}, bus.out_zero, FLAGS & z);
        check({tag, ".neg"}, bus.out_neg, FLAGS & n);
    endtask

    logic [31:0] vec [11];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vec = '{32'h0000_0010, 32'h8000_0001, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678,
                32'hFFFF_FFFF, 32'h0000_0100, 32'h7FFF_FFFF, 32'hA5A5_A5A5, 32'h0F0F_0F0F,
                32'h0000_0042};
        reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();

        // 1: idle after reset
        check("t1.count", bus.count, 3'd0);
        check("t1.in_ready", bus.in_ready, 1'b1);
        check("t1.out_valid", bus.out_valid, 1'b0);
        check("t1.out_s", bus.out_s, 32'h0);
        check("t1.out_op", bus.out_op, 3'd0);
        check("t1.drop", bus.drop_sticky, 1'b0);

        // 2: single push, visible the next cycle
        drive(1'b1, 3'b111, 32'hFFFF_FFE8, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        check_head("t2", 3'b111, 32'hFFFF_FFE8, 1'b0, 1'b0, 1'b1);
        check("t2.count", bus.count, 3'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("t2.count_pop", bus.count, 3'd0);
        check("t2.masked_s", bus.out_s, 32'h0);
        check("t2.masked_neg", bus.out_neg, 1'b0);

        // 3: fill, refused fifth push, drain in order
        drive(1'b1, 3'd0, 32'hFFFF_F0AC, 1'b1, 1'b0); step();
        drive(1'b1, 3'd1, 32'h0FFF_F0AC, 1'b0, 1'b0); step();
        drive(1'b1, 3'd2, 32'h0000_0000, 1'b1, 1'b0); step();
        drive(1'b1, 3'd3, 32'h0000_0001, 1'b0, 1'b0); step();
        check("t3.count_full", bus.count, 3'd4);
        check("t3.in_ready_full", bus.in_ready, 1'b0);
        check_head("t3.e0", 3'd0, 32'hFFFF_F0AC, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 3'd5, 32'hBAD0_0BAD, 1'b1, 1'b1);
        step();
        check("t3.drop", bus.drop_sticky, 1'b1);
        check("t3.count_after_refuse", bus.count, 3'd3);
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        check_head("t3.e1", 3'd1, 32'h0FFF_F0AC, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1; step();
        check_head("t3.e2", 3'd2, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        step();
        check_head("t3.e3", 3'd3, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        check("t3.count_drained", bus.count, 3'd0);
        check("t3.valid_drained", bus.out_valid, 1'b0);

        // 4: streaming push+pop across several pointer wraps
        drive(1'b1, 3'd0, vec[0], 1'b0, 1'b0);
        step();
        check_head("t4.first", 3'd0, vec[0], 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 3'(i), vec[i], i[0], 1'b1);
            step();
            check_head($sformatf("t4.s%0d", i), 3'(i), vec[i], i[0],
                       vec[i] == 32'h0, vec[i][31]);
            check($sformatf("t4.count%0d", i), bus.count, 3'd1);
        end
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
        step();
        check("t4.count_end", bus.count, 3'd0);
        check("t4.drop_held", bus.drop_sticky, 1'b1);

        // 5: popping an empty FIFO
        step();
        step();
        check("t5.count", bus.count, 3'd0);
        check("t5.out_valid", bus.out_valid, 1'b0);
        check("t5.in_ready", bus.in_ready, 1'b1);

        // 6: asynchronous reset with three entries stored
        drive(1'b1, 3'd4, 32'h1111_1111, 1'b0, 1'b0); step();
        drive(1'b1, 3'd5, 32'h2222_2222, 1'b0, 1'b0); step();
        drive(1'b1, 3'd6, 32'h3333_3333, 1'b0, 1'b0); step();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        check("t6.count_pre", bus.count, 3'd3);
        #2 reset = 1'b1;
        #1;
        check("t6.valid_async", bus.out_valid, 1'b0);
        check("t6.s_async", bus.out_s, 32'h0);
        check("t6.count_async", bus.count, 3'd0);
        step();
        reset = 1'b0;
        step();
        check("t6.count_post", bus.count, 3'd0);
        check("t6.valid_post", bus.out_valid, 1'b0);
        check("t6.drop_post", bus.drop_sticky, 1'b0);
        drive(1'b1, 3'd2, 32'h0000_ABCD, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        check_head("t6.fresh", 3'd2, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0);
        check("t6.count_fresh", bus.count, 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
